// File: rtl/pwm_multi_channel.sv
// pwm_multi_channel: parametrised multi-channel PWM generator.
// Duty values are written to a pending bank and copied into the active bank
// only at period boundaries, so a channel never shows a truncated pulse.
// Optional feature macro: PWM_CENTER_ALIGN_EN adds a mode register at 0x81
// that selects center-aligned (up/down) counting. Without it the block is
// edge-aligned only and address 0x81 is ignored.
module pwm_multi_channel #(
  parameter int CHANNELS      = 16,
  parameter int RES_BITS      = 8,
  parameter int PRESCALE_BITS = 12,
  parameter int PRESCALE_RST  = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [7:0]          wr_addr,
  input  logic [15:0]         wr_data,
  input  logic [CHANNELS-1:0] out_en,
  input  logic [CHANNELS-1:0] pwm_en,
  output logic [CHANNELS-1:0] out,
  output logic                period_start
);

  localparam logic [7:0]          ADDR_PRESCALE = 8'h80;
  localparam logic [RES_BITS-1:0] CNT_MAX       = '1;
  localparam logic [RES_BITS-1:0] CNT_ONE       = RES_BITS'(1);

  logic [PRESCALE_BITS-1:0] prescale_div;
  logic [PRESCALE_BITS-1:0] pre_cnt;
  logic [RES_BITS-1:0]      cnt;
  logic [RES_BITS-1:0]      pending [CHANNELS];
  logic [RES_BITS-1:0]      active  [CHANNELS];
  logic [RES_BITS-1:0]      duty_data;
  logic [CHANNELS-1:0]      duty_wr;
  logic [CHANNELS-1:0]      pwm_raw;
  logic                     tick;
  logic                     boundary;
  logic                     prescale_wr;
  logic                     unused_wr_data;

  // Upper write-data bits beyond the register widths are intentionally ignored.
  assign unused_wr_data = ^wr_data;

  assign duty_data   = wr_data[RES_BITS-1:0];
  assign prescale_wr = wr_en && (wr_addr == ADDR_PRESCALE);
  assign tick        = (pre_cnt == prescale_div);

  // Decode duty-register writes: one strobe per channel address.
  always_comb begin
    duty_wr = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      duty_wr[i] = wr_en && (wr_addr == 8'(i));
    end
  end

  // Prescaler: counts 0..P and ticks when it reaches P; a write restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale_div <= PRESCALE_BITS'(PRESCALE_RST);
      pre_cnt      <= '0;
    end else if (prescale_wr) begin
      prescale_div <= wr_data[PRESCALE_BITS-1:0];
      pre_cnt      <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRESCALE_BITS'(1);
    end
  end

`ifdef PWM_CENTER_ALIGN_EN
  localparam logic [7:0] ADDR_MODE = 8'h81;

  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

  dir_t dir;
  logic mode_pending;
  logic mode_active;
  logic mode_wr;

  assign mode_wr  = wr_en && (wr_addr == ADDR_MODE);
  assign boundary = tick && (mode_active ? ((dir == DIR_DOWN) && (cnt == CNT_ONE))
                                         : (cnt == CNT_MAX));

  // Mode register is shadowed and only switches counting style at a boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_pending <= 1'b0;
      mode_active  <= 1'b0;
    end else begin
      if (mode_wr) mode_pending <= wr_data[0];
      if (boundary) mode_active <= mode_wr ? wr_data[0] : mode_pending;
    end
  end

  // Period counter: wraps in edge mode, bounces max -> 1 -> 0 in center mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      dir <= DIR_UP;
    end else if (tick) begin
      if (!mode_active) begin
        cnt <= cnt + CNT_ONE;
        dir <= DIR_UP;
      end else if (dir == DIR_UP) begin
        if (cnt == CNT_MAX) begin
          cnt <= cnt - CNT_ONE;
          dir <= DIR_DOWN;
        end else begin
          cnt <= cnt + CNT_ONE;
        end
      end else begin
        if (cnt == CNT_ONE) dir <= DIR_UP;
        cnt <= cnt - CNT_ONE;
      end
    end
  end
`else
  assign boundary = tick && (cnt == CNT_MAX);

  // Period counter: free-running wrap-around count advanced by the prescaler.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= cnt + CNT_ONE;
    end
  end
`endif

  // Duty banks: pending takes writes, active reloads at each boundary with bypass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        pending[i] <= '0;
        active[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (duty_wr[i]) pending[i] <= duty_data;
        if (boundary) active[i] <= duty_wr[i] ? duty_data : pending[i];
      end
    end
  end

  // Compare each active duty against the counter; all-ones forces a solid high.
  always_comb begin
    pwm_raw = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      pwm_raw[i] = (active[i] == CNT_MAX) || (cnt < active[i]);
    end
  end

  // Register the pin outputs and the boundary pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out          <= '0;
      period_start <= 1'b0;
    end else begin
      out          <= out_en & ((pwm_en & pwm_raw) | ~pwm_en);
      period_start <= boundary;
    end
  end

endmodule

// File: doc/pwm_multi_channel.md
# pwm_multi_channel

Parametrised multi-channel PWM generator, successor to the fixed 16-channel 8-bit PWM peripheral. Channel count, duty resolution and prescaler width are parameters. Duty registers are double-buffered and load only at period boundaries, so updates never produce glitches. The block sits between the SPI register file, which drives its write strobe and the per-channel enables, and the chip output pins.

## Interface
- CHANNELS, 16, number of PWM outputs (1..32)
- RES_BITS, 8, counter and duty resolution in bits (2..16)
- PRESCALE_BITS, 12, prescaler divide-register width (1..16)
- PRESCALE_RST, 12, prescaler register reset value
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  single-cycle register write strobe
- wr_addr  in  8  register address
- wr_data  in  16  write data; only the low RES_BITS or PRESCALE_BITS bits are used
- out_en  in  CHANNELS  per-channel output enable
- pwm_en  in  CHANNELS  per-channel mode: 1 = PWM, 0 = static high
- out  out  CHANNELS  registered channel outputs
- period_start  out  1  one-cycle pulse at every period boundary

## Operation
- Register map:
  - 0x00..CHANNELS-1: duty[i], written to pending[i].
  - 0x80: prescaler divide value P.
  - 0x81: mode register, present only with the macro (see Configuration).
  - Writes to any other address are ignored.
- Prescaler:
  - Counter runs 0..P; a tick is asserted in the cycle the counter equals P, then the counter returns to 0.
  - P = 0 gives a tick every clock.
- Period counter (cnt, RES_BITS wide) advances on each tick.
- Edge-aligned mode:
  - cnt counts 0..2^RES_BITS-1, then wraps to 0.
  - Period is (P+1)·2^RES_BITS clocks.
- Boundary:
  - Defined as the tick on which cnt becomes 0.
  - On the boundary, every active[i] loads pending[i] and period_start pulses.
- Compare for channel i: pwm_raw = (active[i] == all-ones) | (cnt < active[i]).
  - Duty 0 gives constant low.
  - All-ones gives constant high.
- Output: out[i] = out_en[i] & (pwm_en[i] ? pwm_raw : 1).
- Boundary conditions:
  - Duty write coincident with a boundary: new data goes to pending and bypasses directly into active for the new period.
  - Repeated writes within one period: last write wins.
  - Prescaler write: takes effect immediately and clears the prescaler counter; cnt is unchanged.
  - Reset mid-operation: all state cleared immediately; no partial pulse completes.

## Timing
- Reset values:
  - out = 0, period_start = 0.
  - cnt = 0, prescaler counter = 0.
  - pending = 0, active = 0.
  - P = PRESCALE_RST, mode = 0.
- Outputs are registered. Changes in cnt, out_en or pwm_en appear on out one clock later.
- A duty write is visible from the first boundary after the write, or from the same boundary if coincident.
- The first period_start after reset release occurs (P+1)·2^RES_BITS clocks after release.

## Configuration
- PWM_CENTER_ALIGN_EN defined:
  - Register 0x81 bit 0 selects center-aligned mode; the value is shadowed and applied at the next boundary.
  - Center-aligned sequence: cnt counts up 0..2^RES_BITS-1, then down 2^RES_BITS-2..1. Period is (P+1)·(2^(RES_BITS+1)-2) clocks.
  - Boundary is cnt reaching 0 from the up-count start. Compare rule is unchanged, so the pulse is centred on cnt = 0.
- Undefined: edge-aligned only; address 0x81 is ignored; no direction logic is synthesised.

## Test plan
Defaults: CHANNELS=16, RES_BITS=8, P=12; one period is 3328 clocks.
- Reset: assert rst_n mid-pulse -> out = 0 and period_start = 0 immediately; after release, first period_start at 3328 clocks.
- Duty 0x80 on channel 3, out_en[3] = pwm_en[3] = 1 -> out[3] high 1664 of 3328 clocks; all other outputs 0.
- Duty 0x00 -> out constantly low; duty 0xFF -> out constantly high; pwm_en = 0 with out_en = 1 -> constantly high.
- Shadowing: write 0x40 mid-period while duty is 0x80 -> current period stays 1664 high; next period high 832 clocks.
- Prescaler: write P = 0 -> period becomes 256 clocks, starting from the next tick; write to 0x90 -> no register changes.
- With PWM_CENTER_ALIGN_EN, P = 0, mode = 1, duty 0x80 -> period 510 clocks; single contiguous 255-clock high pulse spanning the boundary.
